load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits between the single-cycle datapath and the word-addressed data memory (1 read port, 1 write port, whole-word write enable only).
- Converts byte-addressed loads/stores of byte, halfword or word size into word accesses.
  - Loads: lane extraction plus sign/zero extension.
  - Sub-word stores: two-cycle read-modify-write, because the memory has no byte enables.
- Stalls the datapath for the extra RMW cycle and flags misaligned accesses.

Parameters:
- DEPTH, 32, number of 32-bit words in the attached data memory.
- AW, $clog2(DEPTH), derived word-address width. Must not be overridden independently.

Ports:
- clk  in  1  rising-edge clock, shared with the data memory
- rst  in  1  synchronous, active-high reset
- req  in  1  access request this cycle
- we  in  1  1 = store, 0 = load; qualified by req
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  in  32  byte address
- wdata  in  32  store data; byte/half taken from the low bits
- rdata  out  32  extended load result
- stall  out  1  datapath must hold PC and inputs this cycle
- err  out  1  misaligned or illegal-size access; access is suppressed
- mem_addr  out  AW  word address to the data memory
- mem_wdata  out  32  write data to the data memory
- mem_we  out  1  data-memory write enable
- mem_rdata  in  32  combinational read data from the data memory

Behaviour:
- Address mapping:
  - mem_addr = addr[AW+1:2]; addr[31:AW+2] is ignored (wraps).
  - Lane = addr[1:0]. Little-endian: byte 0 = bits 7:0.
- Alignment:
  - Halfword requires addr[0]=0. Word requires addr[1:0]=00.
  - size=11 is always an error.
  - On error: err=1 the same cycle, mem_we=0, stall=0, rdata=0, no state change.
- FSM has two states, IDLE and RMW_WR. Reset state is IDLE.
- IDLE, load (req & ~we & ~err):
  - Zero latency. mem_addr is driven from addr; rdata is formed combinationally from mem_rdata.
  - Byte: lane byte extended. Half: lane halfword (addr[1] selects) extended. Word: mem_rdata as-is.
  - stall=0.
- IDLE, word store: mem_we=1, mem_wdata=wdata, stall=0. Completes at this clk edge.
- IDLE, byte/half store, cycle 1:
  - mem_we=0 and stall=1.
  - Merge mem_rdata with wdata[7:0] or wdata[15:0] in the addressed lane.
  - At the clk edge, latch the merged word and mem_addr into holding registers; go to RMW_WR.
- RMW_WR, cycle 2:
  - mem_addr = latched address, mem_wdata = latched word, mem_we=1, stall=0.
  - Request inputs are ignored this cycle; the datapath is still holding them.
  - Return to IDLE at the clk edge.
- No request (req=0): mem_we=0, stall=0, err=0, rdata=0, and mem_addr follows addr.
- Sub-word store latency is 2 cycles; all other accesses take 1.
- Reset:
  - While rst=1: mem_we=0, stall=0, err=0, rdata=0.
  - At the edge: state=IDLE, holding registers cleared to 0.
  - A reset asserted in RMW_WR aborts the write. Memory is unchanged and no partial write occurs.
- Back-to-back accesses:
  - After RMW_WR, a new access may be issued in the next cycle.
  - A load of the same word in that cycle sees the merged value, since the memory write completed at the edge.
- Widths: all merge and extension logic is 32-bit. No arithmetic beyond lane select.

Decomposition:
- Shared package holds:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state encodings ST_IDLE, ST_RMW_WR.
- One natural sub-module: lsu_lane_mux, the combinational load extract/extend plus store merge. It is shared by the load path and the RMW merge.

Test Plan:
- Memory word 5 = 32'h8899AABB. Load byte at addr 0x16, sign_ext=1 -> rdata=32'hFFFFFF99, stall=0, mem_we=0. Same with sign_ext=0 -> 32'h00000099.
- Load half at 0x16, sign_ext=1 -> 32'hFFFF8899. Load word at 0x14 -> 32'h8899AABB.
- Store byte wdata=32'h000000CC at 0x15:
  - cycle 1: stall=1, mem_we=0;
  - cycle 2: mem_we=1, mem_addr=5, mem_wdata=32'h8899CCBB;
  - cycle 3: a load word at 0x14 returns 32'h8899CCBB.
- Store word 32'hDEADBEEF at 0x08 -> single cycle, mem_we=1, mem_addr=2, stall=0. Then store half 32'h1234 at 0x0A -> word 2 becomes 32'h1234BEEF after 2 cycles.
- Misaligned half load at 0x13, word store at 0x0A, and size=11 -> err=1, mem_we=0, stall=0, rdata=0, memory unchanged.
- Byte store at 0x00 with rst pulsed during cycle 2 (RMW_WR) -> mem_we=0 that cycle, word 0 unchanged, state IDLE, stall=0 after reset.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states
// and the alignment rule used by the top level.
package load_store_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } lsu_state_e;

    // Size 11 is never legal; bytes are never misaligned.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = |lane;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-addressed data-memory bus: one combinational read port, one
// whole-word write port.
interface load_store_unit_if #(
    parameter int AW = 5
) ();
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic [31:0]   mem_rdata;

    modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
    modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/load_store_unit_lane_mux.sv
// Lane logic shared by loads and the read-modify-write path: extracts and
// extends the addressed lane, and merges store data into the read word.
module lsu_lane_mux
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  lane,
    input  logic [31:0] mem_rdata,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Load extraction and sign/zero extension.
    always_comb begin
        byte_s = 8'h00;
        case (lane)
            2'd0:    byte_s = mem_rdata[7:0];
            2'd1:    byte_s = mem_rdata[15:8];
            2'd2:    byte_s = mem_rdata[23:16];
            2'd3:    byte_s = mem_rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lane[1]) begin
            half_s = mem_rdata[31:16];
        end else begin
            half_s = mem_rdata[15:0];
        end
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & byte_s[7]}}, byte_s};
            SZ_HALF: load_data = {{16{sign_ext & half_s[15]}}, half_s};
            SZ_WORD: load_data = mem_rdata;
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Store merge: replace only the addressed lane of the read word.
    always_comb begin
        merged_data = mem_rdata;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    merged_data[7:0]   = wdata[7:0];
                    2'd1:    merged_data[15:8]  = wdata[7:0];
                    2'd2:    merged_data[23:16] = wdata[7:0];
                    2'd3:    merged_data[31:24] = wdata[7:0];
                    default: merged_data = mem_rdata;
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) begin
                    merged_data[31:16] = wdata;
                end else begin
                    merged_data[15:0] = wdata;
                end
            end
            default: merged_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte-addressed datapath accesses onto a word memory,
// with a two-cycle read-modify-write for sub-word stores.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                we,
    input  logic [1:0]          size,
    input  logic                sign_ext,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic                stall,
    output logic                err,
    load_store_unit_if.master   mem
);

    localparam int AW = $clog2(DEPTH);

    lsu_state_e    state_r;
    logic [AW-1:0] hold_addr_r;
    logic [31:0]   hold_data_r;

    logic          err_s;
    logic [31:0]   load_data_s;
    logic [31:0]   merged_data_s;
    logic [AW-1:0] mem_addr_s;
    logic [31:0]   mem_wdata_s;
    logic          mem_we_s;
    logic          addr_unused_s;

    // Upper address bits wrap around the memory.
    assign addr_unused_s = ^addr[31:AW+2];

    assign err_s = ~rst & req & (state_r == ST_IDLE) & access_err(size, addr[1:0]);

    lsu_lane_mux u_lane_mux (
        .size        (size),
        .sign_ext    (sign_ext),
        .lane        (addr[1:0]),
        .mem_rdata   (mem.mem_rdata),
        .wdata       (wdata[15:0]),
        .load_data   (load_data_s),
        .merged_data (merged_data_s)
    );

    // Memory-side control and load result; reset and errors suppress everything.
    always_comb begin
        mem_addr_s  = addr[AW+1:2];
        mem_wdata_s = wdata;
        mem_we_s    = 1'b0;
        stall       = 1'b0;
        rdata       = 32'h0000_0000;
        if (rst) begin
            mem_we_s = 1'b0;
        end else if (state_r == ST_RMW_WR) begin
            mem_addr_s  = hold_addr_r;
            mem_wdata_s = hold_data_r;
            mem_we_s    = 1'b1;
        end else if (req && !err_s) begin
            if (!we) begin
                rdata = load_data_s;
            end else if (size == SZ_WORD) begin
                mem_we_s = 1'b1;
            end else begin
                stall = 1'b1;
            end
        end else begin
            mem_we_s = 1'b0;
        end
    end

    assign err           = err_s;
    assign mem.mem_addr  = mem_addr_s;
    assign mem.mem_wdata = mem_wdata_s;
    assign mem.mem_we    = mem_we_s;

    // RMW sequencer: capture the merged word in IDLE, write it out in RMW_WR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            hold_addr_r <= '0;
            hold_data_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req && we && !err_s && (size != SZ_WORD)) begin
                        hold_addr_r <= addr[AW+1:2];
                        hold_data_r <= merged_data_s;
                        state_r     <= ST_RMW_WR;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RMW_WR: state_r <= ST_IDLE;
                default:   state_r <= ST_IDLE;
            endcase
        end
    end

endmodule
